// File: rtl/hack_mem_pkg.sv
// Shared types and address map for the Hack data-memory responder.
// Holds the decode helper and the STATUS word layout.
package hack_mem_pkg;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam addr_t TRACE_ADDR  = 15'h6000;
  localparam addr_t STATUS_ADDR = 15'h6001;

  typedef enum logic [1:0] {DEC_RAM, DEC_TRACE, DEC_STATUS, DEC_NONE} dec_e;

  // Trace/status take priority so a deep RAM can never shadow them.
  function automatic dec_e decode(addr_t a, int unsigned depth);
    if (a == TRACE_ADDR)       return DEC_TRACE;
    else if (a == STATUS_ADDR) return DEC_STATUS;
    else if (32'(a) < depth)   return DEC_RAM;
    else                       return DEC_NONE;
  endfunction

  function automatic data_t status_word(logic ovf, logic [3:0] cnt);
    return {ovf, 11'b0, cnt};
  endfunction

endpackage

// File: rtl/hack_trace_fifo.sv
// Synchronous trace FIFO with sticky overflow; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module hack_trace_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 16,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop_ready,
  input  logic          clr_ovf,
  output logic          empty,
  output logic [W-1:0]  data,
  output logic [CW-1:0] count,
  output logic          overflow
);

  logic [W-1:0]  store_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          accept;
  logic          drop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop    = !empty && pop_ready;
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign data   = empty ? '0 : store_q[rd_ptr];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // When full, wr_ptr == rd_ptr: the slot being popped is reused.
      if (accept) begin
        store_q[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/hack_dmem_responder.sv
// Hack CPU M-port data memory: RAM with write-first registered read,
// plus a memory-mapped trace FIFO and its status word.
module hack_dmem_responder
  import hack_mem_pkg::*;
#(
  parameter int RAM_DEPTH  = 16384,
  parameter int FIFO_DEPTH = 8
) (
  input  logic  Clk,
  input  logic  Reset,
  input  logic  we,
  input  logic  re,
  input  addr_t ram_address,
  input  data_t cpu_out_m,
  output data_t in_m,
  output logic  in_m_valid,
  output logic  trace_valid,
  input  logic  trace_ready,
  output data_t trace_data,
  output logic  trace_overflow
);

  localparam int RW = $clog2(RAM_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  data_t          mem [RAM_DEPTH];
  dec_e           dec;
  logic [RW-1:0]  ram_idx;
  data_t          rd_data;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           trace_push;
  logic           clr_ovf;

  assign dec        = decode(ram_address, RAM_DEPTH);
  assign ram_idx    = ram_address[RW-1:0];
  assign trace_push = we && (dec == DEC_TRACE);
  assign clr_ovf    = we && (dec == DEC_STATUS) && cpu_out_m[15];
  assign trace_valid = !fifo_empty;

  always_ff @(posedge Clk) begin
    if (we && dec == DEC_RAM) mem[ram_idx] <= cpu_out_m;
  end

  // A store and load to the same word in one cycle returns the store data.
  always_comb begin
    rd_data = '0;
    case (dec)
      DEC_RAM:    rd_data = we ? cpu_out_m : mem[ram_idx];
      DEC_STATUS: rd_data = status_word(trace_overflow, 4'(fifo_count));
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      in_m       <= '0;
      in_m_valid <= 1'b0;
    end else begin
      in_m_valid <= re;
      if (re) in_m <= rd_data;
    end
  end

  hack_trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_trace_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (trace_push),
    .push_data (cpu_out_m),
    .pop_ready (trace_ready),
    .clr_ovf   (clr_ovf),
    .empty     (fifo_empty),
    .data      (trace_data),
    .count     (fifo_count),
    .overflow  (trace_overflow)
  );

endmodule

// File: tb/tb_hack_dmem_responder.sv
// Scoreboard bench for hack_dmem_responder: a behavioural model predicts load
// responses and trace words, a negedge monitor compares what the DUT presents.
module tb_hack_dmem_responder;
  import hack_mem_pkg::*;

  logic  Clk = 1'b0;
  logic  Reset = 1'b0;
  logic  we = 1'b0;
  logic  re = 1'b0;
  logic  trace_ready = 1'b0;
  addr_t ram_address = '0;
  data_t cpu_out_m = '0;
  data_t in_m;
  data_t trace_data;
  logic  in_m_valid;
  logic  trace_valid;
  logic  trace_overflow;

  always #5 Clk = ~Clk;

  hack_dmem_responder dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .we             (we),
    .re             (re),
    .ram_address    (ram_address),
    .cpu_out_m      (cpu_out_m),
    .in_m           (in_m),
    .in_m_valid     (in_m_valid),
    .trace_valid    (trace_valid),
    .trace_ready    (trace_ready),
    .trace_data     (trace_data),
    .trace_overflow (trace_overflow)
  );

  int    n_vec = 0;
  int    n_err = 0;
  data_t load_q[$];
  data_t trace_q[$];
  data_t mq[$];
  data_t mref[int];
  logic  m_ovf = 1'b0;
  logic  exp_valid = 1'b0;
  data_t last_exp = '0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: state after each rising edge, from the behavioural rules.
  initial begin
    logic  pop, full, drop;
    data_t rd;
    int    a;
    forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
        mq.delete(); trace_q.delete(); load_q.delete();
        m_ovf = 1'b0; exp_valid = 1'b0; last_exp = '0;
      end else begin
        a    = int'(ram_address);
        pop  = (mq.size() > 0) && trace_ready;
        full = (mq.size() == 8);
        drop = 1'b0;
        exp_valid = re;
        if (re) begin
          if (ram_address == STATUS_ADDR) rd = {m_ovf, 11'b0, 4'(mq.size())};
          else if (ram_address == TRACE_ADDR) rd = '0;
          else if (a < 16384) rd = we ? cpu_out_m : (mref.exists(a) ? mref[a] : 16'h0000);
          else rd = '0;
          load_q.push_back(rd);
        end
        if (pop) void'(mq.pop_front());
        if (we && ram_address == TRACE_ADDR) begin
          if (full && !pop) drop = 1'b1;
          else begin
            mq.push_back(cpu_out_m);
            trace_q.push_back(cpu_out_m);
          end
        end
        if (we && ram_address == STATUS_ADDR && cpu_out_m[15]) m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (we && a < 16384) mref[a] = cpu_out_m;
      end
    end
  end

  initial begin
    data_t e;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        chk("rst_in_m", in_m, 16'h0);
        chk("rst_in_m_valid", 16'(in_m_valid), 16'h0);
        chk("rst_trace_valid", 16'(trace_valid), 16'h0);
        chk("rst_trace_data", trace_data, 16'h0);
        chk("rst_overflow", 16'(trace_overflow), 16'h0);
      end else begin
        chk("in_m_valid", 16'(in_m_valid), 16'(exp_valid));
        if (in_m_valid) begin
          if (load_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL load_resp: got %h expected no response", in_m);
          end else begin
            e = load_q.pop_front();
            chk("in_m", in_m, e);
            last_exp = e;
          end
        end else begin
          chk("in_m_hold", in_m, last_exp);
        end
        chk("trace_valid", 16'(trace_valid), 16'(mq.size() > 0));
        chk("trace_overflow", 16'(trace_overflow), 16'(m_ovf));
        if (trace_valid && trace_ready) begin
          if (trace_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL trace_word: got %h expected none", trace_data);
          end else begin
            e = trace_q.pop_front();
            chk("trace_data", trace_data, e);
          end
        end
      end
    end
  end

  task automatic op(logic w, logic r, addr_t a, data_t d);
    we = w; re = r; ram_address = a; cpu_out_m = d;
    @(posedge Clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    addr_t ra;
    int    sel;
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    #1 Reset = 1'b1;

    for (int i = 0; i < 16; i++) op(1'b1, 1'b0, addr_t'(i), data_t'($urandom));

    op(1'b1, 1'b0, 15'h0010, 16'hBEEF);
    op(1'b0, 1'b1, 15'h0010, 16'h0);
    op(1'b1, 1'b1, 15'h0020, 16'h1234);
    op(1'b0, 1'b1, 15'h7000, 16'h0);
    op(1'b0, 1'b1, TRACE_ADDR, 16'h0);

    // Nine pushes into an eight-deep FIFO with the consumer stalled.
    trace_ready = 1'b0;
    for (int i = 1; i <= 9; i++) op(1'b1, 1'b0, TRACE_ADDR, data_t'(i));
    op(1'b0, 1'b1, STATUS_ADDR, 16'h0);
    idle(1);
    trace_ready = 1'b1;
    idle(10);
    op(1'b1, 1'b0, STATUS_ADDR, 16'h8000);

    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) op(1'b1, 1'b0, TRACE_ADDR, data_t'(16'h0100 + i));
    trace_ready = 1'b1;
    op(1'b1, 1'b0, TRACE_ADDR, 16'hAAAA);
    idle(10);

    op(1'b1, 1'b0, STATUS_ADDR, 16'h8000);
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, TRACE_ADDR, data_t'(16'h0200 + i));
    op(1'b0, 1'b1, 15'h0010, 16'h0);
    trace_ready = 1'b1;
    idle(2);
    Reset = 1'b0;
    idle(2);
    Reset = 1'b1;
    trace_ready = 1'b0;
    op(1'b0, 1'b1, STATUS_ADDR, 16'h0);
    idle(2);

    repeat (400) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: ra = addr_t'($urandom_range(0, 15));
        4, 5:       ra = TRACE_ADDR;
        6:          ra = STATUS_ADDR;
        7:          ra = 15'h7000;
        8:          ra = 15'h4000;
        default:    ra = 15'h5FFF;
      endcase
      trace_ready = ($urandom_range(0, 3) != 0);
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, data_t'($urandom));
    end

    trace_ready = 1'b1;
    idle(12);
    chk("load_q_drained", 16'(load_q.size()), 16'h0);
    chk("trace_q_drained", 16'(trace_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
